// File: rtl/q10_mag_cmp.sv
// Registered WIDTH-bit magnitude comparator built from SLICE-bit slices; Q10_SIGNED_EN selects two's complement.
// Latency 1 cycle (out_vld follows in_vld); no backpressure, one compare per cycle.
module q10_mag_cmp #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_vld,
  output logic             Greater,
  output logic             Equal,
  output logic             out_vld
);

  localparam int NS = WIDTH / SLICE;

  logic [NS-1:0] gt_s;
  logic [NS-1:0] eq_s;
  logic          gt_c;
  logic          eq_c;

  genvar k;
  generate
    for (k = 0; k < NS; k++) begin : g_slice
      logic [SLICE-1:0] a_k;
      logic [SLICE-1:0] b_k;
      assign a_k = A[k*SLICE +: SLICE];
      assign b_k = B[k*SLICE +: SLICE];
      assign eq_s[k] = (a_k == b_k);
`ifdef Q10_SIGNED_EN
      if (k == NS-1) begin : g_top_signed
        // Differing sign bits decide the order outright: the non-negative one is larger.
        logic sign_diff;
        assign sign_diff = A[WIDTH-1] ^ B[WIDTH-1];
        assign gt_s[k]   = sign_diff ? ~A[WIDTH-1] : (a_k > b_k);
      end else begin : g_unsigned
        assign gt_s[k] = (a_k > b_k);
      end
`else
      assign gt_s[k] = (a_k > b_k);
`endif
    end
  endgenerate

  // Walk from the MSB slice down; a lower slice only counts while all above are equal.
  always_comb begin
    gt_c = 1'b0;
    eq_c = 1'b1;
    for (int i = NS-1; i >= 0; i--) begin
      gt_c = gt_c | (eq_c & gt_s[i]);
      eq_c = eq_c & eq_s[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Greater <= 1'b0;
      Equal   <= 1'b0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        Greater <= gt_c;
        Equal   <= eq_c;
      end
    end
  end

endmodule

// File: tb/tb_q10_mag_cmp.sv
// Scoreboard bench for q10_mag_cmp: driver queues expected results, a negedge monitor pops and compares.
module tb_q10_mag_cmp;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic        in_vld;
  logic        Greater;
  logic        Equal;
  logic        out_vld;

  typedef struct packed {
    logic gt;
    logic eq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic started  = 1'b0;
  logic rst_seen = 1'b0;
  logic vld_seen = 1'b0;
  logic last_gt  = 1'b0;
  logic last_eq  = 1'b0;

  q10_mag_cmp #(.WIDTH(16), .SLICE(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .B       (B),
    .in_vld  (in_vld),
    .Greater (Greater),
    .Equal   (Equal),
    .out_vld (out_vld)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rst_seen <= rst;
    vld_seen <= in_vld & ~rst;
    if (rst) started <= 1'b1;
  end

  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: decoupled from the driver, compares whatever the DUT presents.
  always @(negedge clk) begin
    if (started) begin
      check("out_vld", out_vld, vld_seen);
      if (rst_seen) begin
        check("rst_greater", Greater, 1'b0);
        check("rst_equal", Equal, 1'b0);
        last_gt = 1'b0;
        last_eq = 1'b0;
      end else if (out_vld) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: out_vld with empty scoreboard at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("greater", Greater, e.gt);
          check("equal", Equal, e.eq);
          check("exclusive", Greater & Equal, 1'b0);
          last_gt = e.gt;
          last_eq = e.eq;
        end
      end else begin
        check("hold_greater", Greater, last_gt);
        check("hold_equal", Equal, last_eq);
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic gt, input logic eq);
    @(posedge clk);
    #1;
    A      = a;
    B      = b;
    in_vld = 1'b1;
    rst    = 1'b0;
    exp_q.push_back('{gt: gt, eq: eq});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_vld = 1'b0;
      rst    = 1'b0;
      A      = 16'h5A5A;
      B      = 16'hA5A5;
    end
  endtask

  initial begin
    rst    = 1'b1;
    in_vld = 1'b0;
    A      = 16'h0;
    B      = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_greater", Greater, 1'b0);
    check("reset_equal", Equal, 1'b0);
    check("reset_out_vld", out_vld, 1'b0);

    issue(16'h8040, 16'h8040, 1'b0, 1'b1);
    issue(16'h1310, 16'h0401, 1'b1, 1'b0);
    issue(16'h8828, 16'h8081, 1'b1, 1'b0);
    issue(16'h8080, 16'h8080, 1'b0, 1'b1);
    issue(16'h8080, 16'h8080, 1'b0, 1'b1);
    idle(3);
`ifdef Q10_SIGNED_EN
    issue(16'h8000, 16'h0001, 1'b0, 1'b0);
    issue(16'h7FFF, 16'h8000, 1'b1, 1'b0);
    issue(16'hFFFF, 16'h0000, 1'b0, 1'b0);
`else
    issue(16'h8000, 16'h0001, 1'b1, 1'b0);
    issue(16'h7FFF, 16'h8000, 1'b0, 1'b0);
    issue(16'hFFFF, 16'h0000, 1'b1, 1'b0);
`endif
    issue(16'h0000, 16'h0000, 1'b0, 1'b1);
    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    issue(16'h0401, 16'h1310, 1'b0, 1'b0);
    issue(16'h1235, 16'h1234, 1'b1, 1'b0);
    issue(16'h1234, 16'h1235, 1'b0, 1'b0);
    issue(16'h8081, 16'h8828, 1'b0, 1'b0);
    issue(16'hFFFE, 16'hFFFF, 1'b0, 1'b0);
    issue(16'h4321, 16'h4321, 1'b0, 1'b1);
    idle(1);

    // Reset on an edge that also carries a valid compare: that compare must vanish.
    issue(16'h2000, 16'h1000, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    in_vld = 1'b1;
    A      = 16'hF000;
    B      = 16'h0001;
    idle(3);
    issue(16'h0010, 16'h0001, 1'b1, 1'b0);
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
